// File: rtl/ffs_pkg.sv
// Shared definitions for the find-first-set encoder and the set-bit iterator.
package ffs_pkg;

  // Iteration order encodings
  localparam logic FFS_MSB_FIRST = 1'b0;
  localparam logic FFS_LSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } ffs_state_e;

  // Index width for a vector of w bits; at least one bit even for w <= 1
  function automatic int ffs_out_width(input int w);
    int wc;
    wc = (w < 2) ? 2 : w;
    return $clog2(wc);
  endfunction

endpackage

// File: rtl/ffs_m.sv
// Combinational find-first-set encoder: highest set bit when SIDE is
// MSB-first, lowest set bit when SIDE is LSB-first. Index counts from bit 0.
module ffs_m
  import ffs_pkg::*;
#(
  parameter int   INPUT_WIDTH = 8,
  parameter logic SIDE        = FFS_MSB_FIRST,
  localparam int  OUT_WIDTH   = ffs_out_width(INPUT_WIDTH)
) (
  input  logic [INPUT_WIDTH-1:0] data_i,
  output logic [OUT_WIDTH-1:0]   idx_o,
  output logic                   valid_o
);

  // Priority scan: the last matching bit in loop order wins
  always_comb begin
    idx_o   = '0;
    valid_o = |data_i;
    if (SIDE == FFS_MSB_FIRST) begin
      for (int i = 0; i < INPUT_WIDTH; i++) begin
        if (data_i[i]) idx_o = OUT_WIDTH'(i);
      end
    end else begin
      for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
        if (data_i[i]) idx_o = OUT_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/ffs_iter_m.sv
// Streaming set-bit iterator: accepts a vector and emits the index of each
// set bit, one beat per cycle, clearing each bit as it is sent. An all-zero
// vector still produces a single beat flagged with out_none.
module ffs_iter_m
  import ffs_pkg::*;
#(
  parameter int   INPUT_WIDTH = 8,
  parameter logic SIDE        = FFS_MSB_FIRST,
  localparam int  W           = (INPUT_WIDTH < 1) ? 1 : INPUT_WIDTH,
  localparam int  OUT_WIDTH   = ffs_out_width(W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_idx,
  output logic                 out_last,
  output logic                 out_none,
  output logic [OUT_WIDTH:0]   out_seq
);

  ffs_state_e           state_q;
  logic [W-1:0]         p_q;
  logic [OUT_WIDTH:0]   seq_q;
  logic                 zero_q;

  logic [OUT_WIDTH-1:0] enc_idx;
  logic                 enc_vld;
  logic                 at_most_one;
  logic [W-1:0]         clr_mask;
  logic                 iter;
  logic                 load;
  logic                 beat_acc;

  ffs_m #(
    .INPUT_WIDTH (W),
    .SIDE        (SIDE)
  ) u_ffs (
    .data_i  (p_q),
    .idx_o   (enc_idx),
    .valid_o (enc_vld)
  );

  // Popcount <= 1 without an adder tree: clearing the lowest set bit leaves zero
  assign at_most_one = ((p_q & (p_q - W'(1))) == '0);

  // One-hot decode of the emitted index, used to retire that bit from P
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < W; i++) begin
      clr_mask[i] = (enc_idx == OUT_WIDTH'(i));
    end
  end

  // Output and handshake decode; in_ready never depends on in_valid
  always_comb begin
    iter      = (state_q == ITER);
    out_valid = iter;
    out_last  = iter & (zero_q | !enc_vld | at_most_one);
    out_none  = iter & zero_q;
    out_idx   = iter ? enc_idx : '0;
    out_seq   = iter ? seq_q : '0;
    in_ready  = !iter | (out_ready & out_last);
    load      = in_valid & in_ready;
    beat_acc  = iter & out_ready;
  end

  // Iterator state: load a new vector (possibly on the final beat) or walk bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      seq_q   <= '0;
      zero_q  <= 1'b0;
    end else if (load) begin
      state_q <= ITER;
      p_q     <= in_data;
      seq_q   <= '0;
      zero_q  <= (in_data == '0);
    end else if (beat_acc) begin
      if (out_last) begin
        state_q <= IDLE;
      end else begin
        p_q   <= p_q & ~clr_mask;
        seq_q <= seq_q + (OUT_WIDTH + 1)'(1);
      end
    end
  end

endmodule
